// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM/source encodings and the alignment test for the fetch PC generator
package pc_pkg;

  typedef enum logic {BOOT, RUN} pc_state_e;

  typedef enum logic [2:0] {SRC_HOLD, SRC_REDIR, SRC_RET, SRC_JUMP, SRC_INC} pc_src_e;

  // lo holds target bits [1:0]; bit0 has already been cleared by target formation
  function automatic logic is_aligned(input logic [1:0] lo, input int ialign);
    return ialign == 4 ? lo == 2'b00 : !lo[0];
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [XLEN-1:0]            push_data,
  output logic [XLEN-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0] count,
  output logic                       empty
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam logic [AW:0]   FULL   = RAS_DEPTH[AW:0];
  localparam logic [AW:0]   ONE_C  = 1;
  localparam logic [AW-1:0] ONE_P  = 1;

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [AW-1:0]   ptr;

  assign top   = mem[ptr];
  assign empty = count == '0;

  // pointer and occupancy: pointer wraps freely, occupancy saturates at the depth
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr   <= ptr + ONE_P;
      count <= count == FULL ? count : count + ONE_C;
    end else if (pop) begin
      ptr   <= ptr - ONE_P;
      count <= count - ONE_C;
    end

  // entry storage: contents are only meaningful below the occupancy, so no reset
  always_ff @(posedge clk)
    if (push) mem[ptr + ONE_P] <= push_data;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch PC generator (redirect > stall > return > jump > increment); RAS enabled by PC_RAS_EN
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int              IALIGN     = 4,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            call_i,
  input  logic            ret_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] prev_pc_o,
  output logic            pc_valid_o,
  output logic            misalign_o,
  output logic            ras_empty_o,
  output logic            ras_underflow_o
);

  pc_state_e       state, state_nxt;
  pc_src_e         src;
  logic [XLEN-1:0] seq, raw, target, ras_top;
  logic            ras_hit, ras_push, ras_pop, misalign_hit, accept, underflow_hit;

  assign seq = pc_o + XLEN'(IALIGN);

`ifdef PC_RAS_EN
  logic                       ras_empty;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic                       unused_count;

  pc_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq),
    .top       (ras_top),
    .count     (ras_count),
    .empty     (ras_empty)
  );

  assign ras_hit       = !ras_empty;
  assign ras_empty_o   = ras_empty;
  assign unused_count  = ^ras_count;
  assign underflow_hit = state == RUN && !redirect_i && !stall_i && ret_i && ras_empty;
`else
  logic unused_ras;

  assign ras_top       = '0;
  assign ras_hit       = 1'b0;
  assign ras_empty_o   = 1'b1;
  assign underflow_hit = 1'b0;
  assign unused_ras    = ras_push | ras_pop;
`endif

  // state register: BOOT after reset, RUN from the first clock after release
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= BOOT;
    else          state <= state_nxt;

  // next state: one-way transition out of BOOT
  always_comb state_nxt = state == BOOT ? RUN : state;

  // FSM output: the PC is a fetch address only once running
  always_comb pc_valid_o = state == RUN;

  // next-PC selection; a return with nothing to pop falls back to the sequential PC
  always_comb begin
    src = state != RUN ? SRC_HOLD :
          redirect_i   ? SRC_REDIR :
          stall_i      ? SRC_HOLD :
          ret_i        ? (ras_hit ? SRC_RET : SRC_INC) :
          jump_i       ? SRC_JUMP : SRC_INC;
    raw = src == SRC_REDIR ? redirect_addr_i :
          src == SRC_RET   ? ras_top :
          src == SRC_JUMP  ? pc_o + imm_i : seq;
    target       = raw & ~XLEN'(1);
    misalign_hit = src != SRC_HOLD && !is_aligned(target[1:0], IALIGN);
    accept       = src != SRC_HOLD && !misalign_hit;
    ras_push     = accept && call_i && (src == SRC_REDIR || src == SRC_JUMP);
    ras_pop      = accept && src == SRC_RET;
  end

  // PC pair update and single-cycle status pulses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pc_o            <= RESET_ADDR;
      prev_pc_o       <= '0;
      misalign_o      <= 1'b0;
      ras_underflow_o <= 1'b0;
    end else begin
      misalign_o      <= misalign_hit;
      ras_underflow_o <= underflow_hit;
      if (accept) begin
        prev_pc_o <= pc_o;
        pc_o      <= target;
      end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized traffic against a queue-based reference model
module tb_pc_fetch_unit;

  localparam int DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 0, reset_n = 0;
  logic        stall_i = 0, redirect_i = 0, jump_i = 0, call_i = 0, ret_i = 0;
  logic [31:0] redirect_addr_i = 0, imm_i = 0;
  logic [31:0] pc_o, prev_pc_o;
  logic        pc_valid_o, misalign_o, ras_empty_o, ras_underflow_o;

  int checks = 0, failures = 0;

  logic [31:0] m_pc, m_prev;
  logic        m_run, m_mis, m_unf;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_fetch_unit #(.XLEN(32), .RESET_ADDR(32'h0), .IALIGN(4), .RAS_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .jump_i          (jump_i),
    .imm_i           (imm_i),
    .call_i          (call_i),
    .ret_i           (ret_i),
    .pc_o            (pc_o),
    .prev_pc_o       (prev_pc_o),
    .pc_valid_o      (pc_valid_o),
    .misalign_o      (misalign_o),
    .ras_empty_o     (ras_empty_o),
    .ras_underflow_o (ras_underflow_o)
  );

  function automatic void model_reset();
    m_pc = 0; m_prev = 0; m_run = 0; m_mis = 0; m_unf = 0;
    m_ras.delete();
  endfunction

  // one clock of the architectural rules, evaluated on the inputs about to be sampled
  function automatic void model_step();
    logic [31:0] t;
    logic        pop;
    m_mis = 0; m_unf = 0; pop = 0;
    if (!m_run) begin m_run = 1; return; end
    if (!redirect_i && stall_i) return;
    if (redirect_i) t = redirect_addr_i;
    else if (ret_i && RAS_ON && m_ras.size() != 0) begin t = m_ras[$]; pop = 1; end
    else if (ret_i) begin t = m_pc + 4; m_unf = RAS_ON; end
    else if (jump_i) t = m_pc + imm_i;
    else t = m_pc + 4;
    t[0] = 1'b0;
    if (t[1]) begin m_mis = 1; return; end
    if (pop) void'(m_ras.pop_back());
    else if (RAS_ON && call_i && (redirect_i || (jump_i && !ret_i))) begin
      m_ras.push_back(m_pc + 4);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end
    m_prev = m_pc;
    m_pc = t;
  endfunction

  task automatic cycle(input logic rd, st, jp, cl, rt, input logic [31:0] ra, im);
    redirect_i = rd; stall_i = st; jump_i = jp; call_i = cl; ret_i = rt;
    redirect_addr_i = ra; imm_i = im;
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    redirect_i = 0; stall_i = 0; jump_i = 0; call_i = 0; ret_i = 0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({pc_o, prev_pc_o, pc_valid_o, misalign_o, ras_empty_o, ras_underflow_o} !== {32'h0, 32'h0, 4'b0010}) begin
      failures++;
      $display("FAIL reset_state pc=%h prev=%h valid=%b mis=%b empty=%b unf=%b required pc=0 prev=0 valid=0 mis=0 empty=1 unf=0",
               pc_o, prev_pc_o, pc_valid_o, misalign_o, ras_empty_o, ras_underflow_o);
    end
    reset_n = 1; #1;
    checks++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_release pc=%h valid=%b required pc=0 valid=0", pc_o, pc_valid_o);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b1) begin
      failures++; $display("FAIL boot_exit pc=%h valid=%b required pc=0 valid=1", pc_o, pc_valid_o);
    end
    for (int i = 1; i <= 2; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (pc_o !== 32'(4 * i) || prev_pc_o !== 32'(4 * (i - 1))) begin
        failures++; $display("FAIL increment pc=%h prev=%h required pc=%h prev=%h", pc_o, prev_pc_o, 4 * i, 4 * (i - 1));
      end
    end
  endtask

  task automatic test_jump();
    cycle(1, 0, 0, 0, 0, 32'h100, 0);
    cycle(0, 0, 1, 0, 0, 0, 32'hFFFF_FFF8);
    checks++;
    if (pc_o !== 32'hF8 || prev_pc_o !== 32'h100) begin
      failures++; $display("FAIL jump_back pc=%h prev=%h required pc=f8 prev=100", pc_o, prev_pc_o);
    end
    cycle(1, 0, 0, 0, 0, 32'h100, 0);
    cycle(0, 0, 1, 1, 0, 0, 32'h12);
    checks++;
    if (misalign_o !== 1'b1 || pc_o !== 32'h100 || prev_pc_o !== 32'hF8 || ras_empty_o !== 1'b1) begin
      failures++; $display("FAIL jump_misalign mis=%b pc=%h prev=%h empty=%b required mis=1 pc=100 prev=f8 empty=1",
                           misalign_o, pc_o, prev_pc_o, ras_empty_o);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (misalign_o !== 1'b0 || pc_o !== 32'h104) begin
      failures++; $display("FAIL misalign_pulse mis=%b pc=%h required mis=0 pc=104", misalign_o, pc_o);
    end
  endtask

  task automatic test_priority();
    cycle(1, 1, 1, 0, 0, 32'h2000, 32'h40);
    checks++;
    if (pc_o !== 32'h2000 || prev_pc_o !== 32'h104) begin
      failures++; $display("FAIL redirect_priority pc=%h prev=%h required pc=2000 prev=104", pc_o, prev_pc_o);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 1, 0, 1, 0, 32'h40);
      checks++;
      if (pc_o !== 32'h2000 || prev_pc_o !== 32'h104 || ras_underflow_o !== 1'b0) begin
        failures++; $display("FAIL stall_hold pc=%h prev=%h unf=%b required pc=2000 prev=104 unf=0", pc_o, prev_pc_o, ras_underflow_o);
      end
    end
  endtask

  task automatic test_wrap();
    cycle(1, 0, 0, 0, 0, 32'hFFFF_FFFC, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pc_o !== 32'h0 || prev_pc_o !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap pc=%h prev=%h required pc=0 prev=fffffffc", pc_o, prev_pc_o);
    end
    cycle(1, 0, 0, 0, 0, 32'h201, 0);
    checks++;
    if (pc_o !== 32'h200 || misalign_o !== 1'b0) begin
      failures++; $display("FAIL bit0_clear pc=%h mis=%b required pc=200 mis=0", pc_o, misalign_o);
    end
  endtask

  task automatic test_ras();
    logic [31:0] ret_exp [4] = '{32'h54, 32'h44, 32'h34, 32'h24};
    cycle(1, 0, 0, 0, 0, 32'h10, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1, 0, 0, 32'h10);
    checks++;
    if (pc_o !== 32'h60 || ras_empty_o !== !RAS_ON) begin
      failures++; $display("FAIL call_chain pc=%h empty=%b required pc=60 empty=%b", pc_o, ras_empty_o, !RAS_ON);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (pc_o !== (RAS_ON ? ret_exp[i] : 32'h64 + 32'(4 * i))) begin
        failures++; $display("FAIL ret_target pc=%h required %h", pc_o, RAS_ON ? ret_exp[i] : 32'h64 + 32'(4 * i));
      end
    end
    cycle(0, 0, 0, 1, 1, 0, 0);
    checks++;
    if (ras_underflow_o !== RAS_ON || ras_empty_o !== 1'b1 || pc_o !== (RAS_ON ? 32'h28 : 32'h74)) begin
      failures++; $display("FAIL ret_underflow unf=%b empty=%b pc=%h required unf=%b empty=1 pc=%h",
                           ras_underflow_o, ras_empty_o, pc_o, RAS_ON, RAS_ON ? 32'h28 : 32'h74);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (ras_underflow_o !== 1'b0 || ras_empty_o !== 1'b1) begin
      failures++; $display("FAIL underflow_pulse unf=%b empty=%b required unf=0 empty=1", ras_underflow_o, ras_empty_o);
    end
  endtask

  task automatic test_async_reset();
    cycle(1, 0, 0, 1, 0, 32'h300, 0);
    cycle(0, 0, 1, 1, 0, 0, 32'h20);
    checks++;
    if (ras_empty_o !== !RAS_ON || pc_o !== 32'h320) begin
      failures++; $display("FAIL pre_reset_ras empty=%b pc=%h required empty=%b pc=320", ras_empty_o, pc_o, !RAS_ON);
    end
    #2 reset_n = 0;
    model_reset();
    #1;
    checks++;
    if ({pc_o, prev_pc_o, pc_valid_o, misalign_o, ras_empty_o, ras_underflow_o} !== {32'h0, 32'h0, 4'b0010}) begin
      failures++;
      $display("FAIL async_reset pc=%h prev=%h valid=%b mis=%b empty=%b unf=%b required pc=0 prev=0 valid=0 mis=0 empty=1 unf=0",
               pc_o, prev_pc_o, pc_valid_o, misalign_o, ras_empty_o, ras_underflow_o);
    end
    @(posedge clk); #1;
    reset_n = 1; #1;
    cycle(0, 0, 1, 0, 1, 0, 32'h40);
    checks++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b1 || ras_underflow_o !== 1'b0) begin
      failures++; $display("FAIL boot_ignores pc=%h valid=%b unf=%b required pc=0 valid=1 unf=0", pc_o, pc_valid_o, ras_underflow_o);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (pc_o !== 32'h4) begin
      failures++; $display("FAIL post_reset_inc pc=%h required 4", pc_o);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, im;
      a  = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
      im = 32'($urandom_range(0, 511)) - 32'd256;
      if ($urandom_range(0, 3) != 0) im = im & 32'hFFFF_FFFC;
      cycle($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, a, im);
      checks++;
      if ({pc_o, prev_pc_o, pc_valid_o, misalign_o, ras_empty_o, ras_underflow_o} !==
          {m_pc, m_prev, m_run, m_mis, m_ras.size() == 0, m_unf}) begin
        failures++;
        $display("FAIL random_%0d pc=%h prev=%h valid=%b mis=%b empty=%b unf=%b required pc=%h prev=%h valid=%b mis=%b empty=%b unf=%b",
                 n, pc_o, prev_pc_o, pc_valid_o, misalign_o, ras_empty_o, ras_underflow_o,
                 m_pc, m_prev, m_run, m_mis, m_ras.size() == 0, m_unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_priority();
    test_wrap();
    test_ras();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
